// File: rtl/bound_flasher_mealy.sv
`default_nettype none
// ============================================================================
//  Module      : bound_flasher_mealy
//  Description : 16-lamp bound flasher. A single flick input starts a fixed
//                light-and-dim sequence; flick at the L5/L10 kickback points
//                sends the sequence back to an earlier dimming phase.
//                Mealy FSM: each decision looks at the post-step lamp pattern
//                and flick on the same clock edge.
//  Ports       : clk   - system clock, rising edge
//                rst   - asynchronous reset, active low
//                flick - start / kickback request, level-sampled
//                lamps - registered lamp drive, lamps[0]=L0 .. lamps[15]=L15
//  Revision    : 1.0  initial release
// ============================================================================
module bound_flasher_mealy (
    input  logic        clk,
    input  logic        rst,
    input  logic        flick,
    output logic [15:0] lamps
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        UP_L5    = 4'd1,
        DN_L0    = 4'd2,
        UP_L5K   = 4'd3,
        UP_L10K  = 4'd4,
        DN_L5    = 4'd5,
        UP_L5K2  = 4'd6,
        UP_L10K2 = 4'd7,
        UP_L15   = 4'd8,
        DN_ALL   = 4'd9
    } state_t;

    localparam logic [15:0] c_none = 16'h0000;
    localparam logic [15:0] c_l0   = 16'h0001;
    localparam logic [15:0] c_l4   = 16'h001F;
    localparam logic [15:0] c_l5   = 16'h003F;
    localparam logic [15:0] c_l10  = 16'h07FF;
    localparam logic [15:0] c_all  = 16'hFFFF;

    state_t state;

    // Candidate next patterns; only one lamp changes per edge.
    logic [15:0] w_up;
    logic [15:0] w_dn;

    assign w_up = {lamps[14:0], 1'b1};
    assign w_dn = {1'b0, lamps[15:1]};

    // All transition tests compare against the post-step pattern (w_up/w_dn),
    // so the phase changes on the same edge that reaches the boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lamps <= c_none;
        end else begin
            case (state)
                IDLE: begin
                    if (flick) begin
                        lamps <= c_l0;
                        state <= UP_L5;
                    end else begin
                        lamps <= c_none;
                    end
                end
                UP_L5: begin
                    lamps <= w_up;
                    if (w_up == c_l5) state <= DN_L0;
                end
                DN_L0: begin
                    lamps <= w_dn;
                    if (w_dn == c_none) state <= UP_L5K;
                end
                UP_L5K: begin
                    lamps <= w_up;
                    if (w_up == c_l5) state <= flick ? DN_L0 : UP_L10K;
                end
                UP_L10K: begin
                    lamps <= w_up;
                    if (w_up == c_l10) state <= flick ? DN_L0 : DN_L5;
                end
                DN_L5: begin
                    lamps <= w_dn;
                    if (w_dn == c_l4) state <= UP_L5K2;
                end
                UP_L5K2: begin
                    lamps <= w_up;
                    if (w_up == c_l5) state <= flick ? DN_L5 : UP_L10K2;
                end
                UP_L10K2: begin
                    lamps <= w_up;
                    if (w_up == c_l10) state <= flick ? DN_L5 : UP_L15;
                end
                UP_L15: begin
                    lamps <= w_up;
                    if (w_up == c_all) state <= DN_ALL;
                end
                DN_ALL: begin
                    lamps <= w_dn;
                    if (w_dn == c_none) state <= IDLE;
                end
                // Unused codes recover to a clean idle.
                default: begin
                    state <= IDLE;
                    lamps <= c_none;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_mealy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bound_flasher_mealy
//  Description : Self-checking bench for bound_flasher_mealy. The reference
//                model tracks the number of lit lamps and a phase index driven
//                by a table of (direction, boundary, kickback target, next).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bound_flasher_mealy;

    logic        clk;
    logic        rst;
    logic        flick;
    logic [15:0] lamps;

    bound_flasher_mealy dut (
        .clk   (clk),
        .rst   (rst),
        .flick (flick),
        .lamps (lamps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        int          s;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Phase table: lit-count direction, boundary count, kickback target
    // (-1 = none) and the phase that follows a normal boundary.
    int dirs [10] = '{0, 1, -1, 1, 1, -1, 1, 1, 1, -1};
    int tgt  [10] = '{0, 6, 0, 6, 11, 5, 6, 11, 16, 0};
    int kick [10] = '{-1, -1, -1, 2, 2, -1, 5, 5, -1, -1};
    int nxt  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

    int m_phase = 0;
    int m_n     = 0;

    function automatic logic [15:0] pattern(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[15:0];
    endfunction

    task automatic model_step(input logic f);
        if (m_phase == 0) begin
            if (f) begin
                m_n     = 1;
                m_phase = 1;
            end else begin
                m_n = 0;
            end
        end else begin
            m_n = m_n + dirs[m_phase];
            if (m_n == tgt[m_phase])
                m_phase = (kick[m_phase] >= 0 && f) ? kick[m_phase] : nxt[m_phase];
        end
    endtask

    task automatic check(input string name, input logic [15:0] al, input int as,
                         input logic [15:0] el, input int es);
        n_checks++;
        if (al === el && as == es) n_pass++;
        else $display("FAIL %s: lamps=%h state=%0d, expected lamps=%h state=%0d",
                      name, al, as, el, es);
    endtask

    // One clock of stimulus; inputs change on the falling edge.
    task automatic step(input logic f, input logic r);
        exp_t e;
        @(negedge clk);
        rst   = r;
        flick = f;
        if (!r) begin
            #1;
            check("async_reset", lamps, int'(dut.state), 16'h0000, 0);
            m_phase = 0;
            m_n     = 0;
        end else begin
            model_step(f);
        end
        e.l = pattern(m_n);
        e.s = m_phase;
        q.push_back(e);
    endtask

    task automatic run_to_idle(input int kp, input int kicks);
        int k;
        bit f;
        k = kicks;
        for (int i = 0; i < 400 && m_phase != 0; i++) begin
            f = (kp > 0 && m_phase == kp && m_n + dirs[kp] == tgt[kp] && k > 0);
            if (f) k--;
            step(f, 1'b1);
        end
    endtask

    // Monitor: registered outputs are sampled 1 time unit after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sequence", lamps, int'(dut.state), e.l, e.s);
            end
        end
    end

    initial begin
        rst   = 1'b0;
        flick = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);

        // Nominal run from a single-cycle pulse.
        step(1'b1, 1'b1);
        run_to_idle(0, 0);
        repeat (2) step(1'b0, 1'b1);

        // Kickbacks at each of the four kickback points, twice each.
        for (int kp = 3; kp <= 7; kp++) begin
            if (kp != 5) begin
                step(1'b1, 1'b1);
                run_to_idle(kp, 2);
                step(1'b0, 1'b1);
            end
        end

        // Reset while dimming in phase 2.
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && !(m_phase == 2 && m_n == 3); i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);

        // Continuous flick loops between phases 2 and 3; release finishes.
        repeat (120) step(1'b1, 1'b1);
        run_to_idle(0, 0);

        // Flick still high when the sequence lands in idle restarts it.
        step(1'b1, 1'b1);
        for (int i = 0; i < 100 && !(m_phase == 9 && m_n == 1); i++) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        run_to_idle(0, 0);
        step(1'b0, 1'b1);

        // Randomized flick activity.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) == 0), 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d outstanding, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bound_flasher_mealy.md
Name: bound_flasher_mealy

Overview:
- 16-lamp "bound flasher" controller.
- A single `flick` control input starts a fixed light-and-dim sequence.
- At two kickback points, `flick` redirects the sequence back to an earlier dimming phase.
- Mealy FSM: the next state and lamp update depend on the current state, the post-step lamp pattern and `flick`, all sampled on the same clock edge.
- Sits between a debounced user switch and the lamp driver.

Parameters:
- None. Lamp count is fixed at 16.

Ports:
- `clk`   input   1   system clock, rising-edge active
- `rst`   input   1   asynchronous, active-low reset
- `flick` input   1   start / kickback request, level-sampled on `clk` rising edge
- `lamps` output  16  lamp drive; `lamps[0]` = L0 … `lamps[15]` = L15; registered

Behaviour:
- Reset (`rst`=0, asynchronous): `state`=IDLE(0), `lamps`=16'h0000. Held while `rst`=0; operation resumes on the first clock edge after release. Reset mid-sequence aborts to IDLE immediately.
- State register named `state`, 4 bits, encodings 0–9 as listed below.
- Step operations, at most one lamp changes per clock edge:
  - UP: `lamps` <= {`lamps`[14:0],1'b1}
  - DN: `lamps` <= {1'b0,`lamps`[15:1]}
  - Transition tests below use the NEW (post-step) `lamps` value.
- States and transitions:
  - 0 IDLE: `lamps` forced to 0. If `flick`=1, do UP (L0 on) and go to 1; else stay.
  - 1 UP_L5: UP; when new=16'h003F go to 2. No kickback here.
  - 2 DN_L0: DN; when new=16'h0000 go to 3.
  - 3 UP_L5K: UP; when new=16'h003F: `flick`=1 -> 2 (kickback at L5), else -> 4.
  - 4 UP_L10K: UP; when new=16'h07FF: `flick`=1 -> 2 (kickback at L10), else -> 5.
  - 5 DN_L5: DN; when new=16'h001F (L0–L4 on) go to 6.
  - 6 UP_L5K2: UP; when new=16'h003F: `flick`=1 -> 5, else -> 7.
  - 7 UP_L10K2: UP; when new=16'h07FF: `flick`=1 -> 5, else -> 8.
  - 8 UP_L15: UP; when new=16'hFFFF go to 9.
  - 9 DN_ALL: DN; when new=16'h0000 go to 0.
- `flick` matters only in IDLE and at the four kickback edges: state 3 at L5, state 4 at L10, state 6 at L5, state 7 at L10. It is ignored at every other edge.
- Kickbacks may repeat without limit while `flick` stays high at each kickback edge.
- If `flick` is still high when the sequence returns to IDLE, the next edge restarts the sequence.
- Undefined state codes (10–15): go to IDLE with `lamps`=0 on the next edge.

Nominal sequence length without kickback: 56 edges from the start edge back to IDLE. Edges per state:
- state 1: 6
- state 2: 6
- state 3: 6
- state 4: 5
- state 5: 6
- state 6: 1
- state 7: 5
- state 8: 5
- state 9: 16

Test Plan:
- Reset: assert `rst`=0 mid-sequence (state 2) -> `lamps`=0000 and `state`=0 immediately, without waiting for a clock. After release with `flick`=0 -> stays IDLE.
- Nominal run: one-cycle `flick` pulse in IDLE. Sequence must be 0001…003F, then 001F…0000, then 0001…07FF, then 03FF…001F, then 003F…FFFF, then 7FFF…0000. Back to IDLE after 56 edges; `lamps` changes by exactly one bit per edge.
- Kickback at L5, state 3: hold `flick`=1 when `lamps` reaches 003F in state 3 -> next state 2, `lamps` 001F down to 0000. Then state 3 again; with `flick`=0 proceeds to 07FF.
- Kickback at L10, state 4: `flick`=1 on the edge reaching 07FF -> state 2, `lamps` dims 03FF down to 0000, then state 3 resumes.
- Kickbacks in states 6/7: `flick`=1 at 003F (state 6) -> state 5, 001F. `flick`=1 at 07FF (state 7) -> state 5, dims to 001F, then state 6. With `flick`=0 afterwards, completes to FFFF then 0000.
- Continuous `flick`=1: loops 3->2->3 indefinitely, never reaching state 4. Releasing `flick` lets the sequence finish normally, then IDLE.
